// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file port master.
//   - op codes carried on req_op
//   - FSM state encoding
//   - default bus/array geometry
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_REGS_DEF   = 8;
    localparam int ADDR_WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ2 = 2'b10,
        OP_MOVE  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_WR,
        ST_RESP
    } state_e;

    // Ops whose second address takes part in the access (and the range check).
    function automatic logic op_uses_b(input op_e op);
        return (op == OP_READ2) || (op == OP_MOVE);
    endfunction

endpackage

// File: rtl/regfile_port_master_if.sv
// Bundle of request/response handshake and register-array strobes/buses.
//   master : the port master (accepts requests, drives strobes, samples read bus)
//   slave  : the requester plus register array on the other side
interface regfile_port_master_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr_a;
    logic [ADDR_WIDTH-1:0] req_addr_b;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data_a;
    logic [DATA_WIDTH-1:0] rsp_data_b;
    logic                  rsp_err;
    logic [NUM_REGS-1:0]   reg_read_en;
    logic [NUM_REGS-1:0]   reg_write_en;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic [DATA_WIDTH-1:0] reg_read_bus;

    modport master (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready, reg_read_bus,
        output req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err,
               reg_read_en, reg_write_en, reg_write_data
    );

    modport slave (
        output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready, reg_read_bus,
        input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err,
               reg_read_en, reg_write_en, reg_write_data
    );
endinterface

// File: rtl/reg_addr_decoder.sv
// Register address decoder.
//   addr_i   : register address
//   en_i     : gates the one-hot output
//   onehot_o : one bit per register, set for addr_i when enabled and in range
//   oor_o    : addr_i >= NUM_REGS (independent of en_i)
module reg_addr_decoder #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  en_i,
    output logic [NUM_REGS-1:0]   onehot_o,
    output logic                  oor_o
);
    // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
        assign onehot_o[i] = en_i && (addr_i == ADDR_WIDTH'(i));
    end

    assign oor_o = {1'b0, addr_i} >= LIMIT;
endmodule

// File: rtl/regfile_port_master.sv
// Register-file port master: turns READ/WRITE/READ2/MOVE requests into
// registered one-hot read/write strobes, drives shared write data and samples
// the shared read bus at the edge ending each read cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/response handshake and register-array signals
module regfile_port_master
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_master_if.master bus
);
    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [NUM_REGS-1:0]   rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [NUM_REGS-1:0]   oh_a, oh_b;
    logic                  oor_a, oor_b, req_ready, accept, addr_err;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = bus.req_valid && req_ready;

    // Request fields are latched on accept; decode from the next-state copies
    // so strobes can be registered in the same edge that accepts.
    assign op_d     = accept ? op_e'(bus.req_op) : op_q;
    assign addr_a_d = accept ? bus.req_addr_a : addr_a_q;
    assign addr_b_d = accept ? bus.req_addr_b : addr_b_q;

    reg_addr_decoder #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_dec_a (
        .addr_i(addr_a_d), .en_i(1'b1), .onehot_o(oh_a), .oor_o(oor_a)
    );
    reg_addr_decoder #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_dec_b (
        .addr_i(addr_b_d), .en_i(1'b1), .onehot_o(oh_b), .oor_o(oor_b)
    );

    assign addr_err = oor_a || (op_uses_b(op_d) && oor_b);

    always_comb begin
        state_d   = state_q;
        wr_data_d = '0;
        rsp_a_d   = rsp_a_q;
        rsp_b_d   = rsp_b_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            ST_IDLE: if (accept) begin
                rsp_a_d   = '0;
                rsp_b_d   = '0;
                rsp_err_d = 1'b0;
                if (addr_err) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (op_d == OP_WRITE) begin
                    wr_data_d = bus.req_wdata;
                    rsp_a_d   = bus.req_wdata;
                    state_d   = ST_WR;
                end else begin
                    state_d = ST_RD_A;
                end
            end
            ST_RD_A: begin
                rsp_a_d = bus.reg_read_bus;
                if (op_q == OP_READ2) begin
                    state_d = ST_RD_B;
                end else if (op_q == OP_MOVE) begin
                    wr_data_d = bus.reg_read_bus;
                    state_d   = ST_WR;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RD_B: begin
                rsp_b_d = bus.reg_read_bus;
                state_d = ST_RESP;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Strobes follow the state being entered, so they are valid for
        // exactly that state's cycle and zero in IDLE/RESP.
        rd_en_d = '0;
        wr_en_d = '0;
        if (state_d == ST_RD_A) rd_en_d = oh_a;
        if (state_d == ST_RD_B) rd_en_d = oh_b;
        if (state_d == ST_WR)   wr_en_d = (op_d == OP_MOVE) ? oh_b : oh_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_READ;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            wr_data_q <= '0;
            rsp_a_q   <= '0;
            rsp_b_q   <= '0;
            rsp_err_q <= 1'b0;
            rd_en_q   <= '0;
            wr_en_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            wr_data_q <= wr_data_d;
            rsp_a_q   <= rsp_a_d;
            rsp_b_q   <= rsp_b_d;
            rsp_err_q <= rsp_err_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.rsp_valid      = (state_q == ST_RESP);
    assign bus.rsp_data_a     = rsp_a_q;
    assign bus.rsp_data_b     = rsp_b_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.reg_read_en    = rd_en_q;
    assign bus.reg_write_en   = wr_en_q;
    assign bus.reg_write_data = wr_data_q;
endmodule

// File: tb/tb_regfile_port_master.sv
// Bench for regfile_port_master: an 8-register and a 6-register instance,
// each with a behavioural register array on its strobes, checked against an
// architectural reference model (per-op expected strobes, data and latency).
module tb_regfile_port_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_master_if #(.DATA_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3)) if8 ();
    regfile_port_master_if #(.DATA_WIDTH(16), .NUM_REGS(6), .ADDR_WIDTH(3)) if6 ();

    regfile_port_master #(.DATA_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3)) dut8 (
        .clk(clk), .rst(rst), .bus(if8.master));
    regfile_port_master #(.DATA_WIDTH(16), .NUM_REGS(6), .ADDR_WIDTH(3)) dut6 (
        .clk(clk), .rst(rst), .bus(if6.master));

    // Shared request drive; sel picks the target instance (0: 8 regs, 1: 6 regs).
    logic        sel = 1'b0;
    logic        q_valid = 1'b0, q_rsp_ready = 1'b0;
    logic [1:0]  q_op = 2'b00;
    logic [2:0]  q_a = '0, q_b = '0;
    logic [15:0] q_wd = '0;

    assign if8.req_valid  = q_valid && !sel;
    assign if6.req_valid  = q_valid && sel;
    assign if8.rsp_ready  = q_rsp_ready && !sel;
    assign if6.rsp_ready  = q_rsp_ready && sel;
    assign if8.req_op     = q_op;   assign if6.req_op     = q_op;
    assign if8.req_addr_a = q_a;    assign if6.req_addr_a = q_a;
    assign if8.req_addr_b = q_b;    assign if6.req_addr_b = q_b;
    assign if8.req_wdata  = q_wd;   assign if6.req_wdata  = q_wd;

    // Register arrays: capture on posedge, drive read bus on negedge.
    logic [15:0] regs8 [8] = '{default: 16'h0};
    logic [15:0] regs6 [8] = '{default: 16'h0};
    logic [15:0] bus8_v = '0, bus6_v = '0;
    assign if8.reg_read_bus = bus8_v;
    assign if6.reg_read_bus = bus6_v;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (if8.reg_write_en[i]) regs8[i] <= if8.reg_write_data;
        for (int i = 0; i < 6; i++) if (if6.reg_write_en[i]) regs6[i] <= if6.reg_write_data;
    end
    always @(negedge clk) begin
        bus8_v = 16'hzzzz;
        bus6_v = 16'hzzzz;
        for (int i = 0; i < 8; i++) if (if8.reg_read_en[i]) bus8_v = regs8[i];
        for (int i = 0; i < 6; i++) if (if6.reg_read_en[i]) bus6_v = regs6[i];
    end

    // Observed outputs of the selected instance.
    logic        o_req_ready, o_rsp_valid, o_err;
    logic [15:0] o_a, o_b, o_wd;
    logic [7:0]  o_rd, o_wr;
    always_comb begin
        o_req_ready = if8.req_ready;  o_rsp_valid = if8.rsp_valid;  o_err = if8.rsp_err;
        o_a  = if8.rsp_data_a;  o_b = if8.rsp_data_b;  o_wd = if8.reg_write_data;
        o_rd = if8.reg_read_en; o_wr = if8.reg_write_en;
        if (sel) begin
            o_req_ready = if6.req_ready;  o_rsp_valid = if6.rsp_valid;  o_err = if6.rsp_err;
            o_a  = if6.rsp_data_a;  o_b = if6.rsp_data_b;  o_wd = if6.reg_write_data;
            o_rd = {2'b00, if6.reg_read_en}; o_wr = {2'b00, if6.reg_write_en};
        end
    end

    // Architectural reference contents, one array per instance.
    logic [15:0] ref_mem [2][8] = '{default: '{default: 16'h0}};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: model, drive, check strobes per cycle, latency,
    // response held for `hold` extra cycles, then handshake.
    task automatic run(input bit s, input logic [1:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [15:0] wd, input int hold);
        int          n, elen, cyc;
        bit          err;
        logic [15:0] ea, eb;
        logic [7:0]  erd [4];
        logic [7:0]  ewr [4];
        logic [15:0] ewd [4];
        n    = s ? 6 : 8;
        err  = (int'(a) >= n) || ((op == 2'd2 || op == 2'd3) && int'(b) >= n);
        elen = 0; ea = '0; eb = '0;
        for (int k = 0; k < 4; k++) begin erd[k] = '0; ewr[k] = '0; ewd[k] = '0; end
        if (!err) begin
            case (op)
                2'd0: begin ea = ref_mem[s][a]; erd[0] = 8'd1 << a; elen = 1; end
                2'd1: begin ref_mem[s][a] = wd; ea = wd; ewr[0] = 8'd1 << a; ewd[0] = wd; elen = 1; end
                2'd2: begin ea = ref_mem[s][a]; eb = ref_mem[s][b];
                            erd[0] = 8'd1 << a; erd[1] = 8'd1 << b; elen = 2; end
                default: begin ea = ref_mem[s][a]; ref_mem[s][b] = ea;
                            erd[0] = 8'd1 << a; ewr[1] = 8'd1 << b; ewd[1] = ea; elen = 2; end
            endcase
        end

        @(negedge clk);
        sel = s; q_valid = 1'b1; q_op = op; q_a = a; q_b = b; q_wd = wd;
        #1 chk("req_ready_idle", o_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        q_valid = 1'b0;
        cyc = 0;
        while (!o_rsp_valid && cyc < 4) begin
            chk("read_en", o_rd, erd[cyc]);
            chk("write_en", o_wr, ewr[cyc]);
            if (ewr[cyc] != 0) chk("write_data", o_wd, ewd[cyc]);
            chk("req_ready_busy", o_req_ready, 0);
            cyc++;
            @(negedge clk);
        end
        chk("latency", cyc, elen);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("rsp_valid", o_rsp_valid, 1);
            chk("rsp_data_a", o_a, ea);
            chk("rsp_data_b", o_b, eb);
            chk("rsp_err", o_err, err);
            chk("req_ready_resp", o_req_ready, 0);
            chk("strobes_resp", {o_rd, o_wr}, 0);
        end
        q_rsp_ready = 1'b1;
        @(negedge clk);
        q_rsp_ready = 1'b0;
        chk("rsp_valid_drop", o_rsp_valid, 0);
        chk("req_ready_back", o_req_ready, 1);
    endtask

    initial begin
        // Reset state while rst is held.
        @(negedge clk);
        chk("rst_req_ready", if8.req_ready, 0);
        chk("rst_rsp_valid", if8.rsp_valid, 0);
        chk("rst_strobes", {if8.reg_read_en, if8.reg_write_en}, 0);
        chk("rst_wdata", if8.reg_write_data, 0);
        chk("rst_rsp", {if8.rsp_data_a, if8.rsp_data_b, 15'd0, if8.rsp_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_release_ready", if8.req_ready, 1);

        // Directed sequence on the 8-register instance.
        run(0, 2'd1, 3'd3, 3'd0, 16'hBEEF, 0);
        run(0, 2'd0, 3'd3, 3'd0, 16'h0000, 1);
        run(0, 2'd1, 3'd1, 3'd0, 16'h0011, 0);
        run(0, 2'd1, 3'd6, 3'd0, 16'h0066, 0);
        run(0, 2'd2, 3'd1, 3'd6, 16'h0000, 2);
        run(0, 2'd3, 3'd6, 3'd2, 16'h0000, 0);
        run(0, 2'd0, 3'd2, 3'd0, 16'h0000, 0);
        run(0, 2'd3, 3'd3, 3'd3, 16'h0000, 0);
        run(0, 2'd0, 3'd3, 3'd0, 16'h0000, 0);

        // 6-register instance: in-range traffic and out-of-range errors.
        run(1, 2'd1, 3'd5, 3'd0, 16'h5555, 0);
        run(1, 2'd0, 3'd7, 3'd0, 16'h0000, 5);
        run(1, 2'd2, 3'd0, 3'd6, 16'h0000, 1);
        run(1, 2'd3, 3'd5, 3'd7, 16'h0000, 0);
        run(1, 2'd1, 3'd6, 3'd0, 16'hDEAD, 0);
        run(1, 2'd0, 3'd5, 3'd0, 16'h0000, 0);

        // Reset in the write cycle of a MOVE 1 -> 5: abandoned, target unchanged.
        @(negedge clk);
        sel = 1'b0; q_valid = 1'b1; q_op = 2'd3; q_a = 3'd1; q_b = 3'd5;
        @(posedge clk);
        @(negedge clk);
        q_valid = 1'b0;
        @(posedge clk);
        #1 chk("mv_wr_strobe", if8.reg_write_en, 8'b0010_0000);
        rst = 1'b1;
        #1 chk("rst_async_strobes", {if8.reg_read_en, if8.reg_write_en}, 0);
        chk("rst_async_rsp", if8.rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst2_req_ready", if8.req_ready, 1);
        chk("rst2_target", regs8[5], ref_mem[0][5]);
        @(negedge clk);
        chk("rst2_no_rsp", if8.rsp_valid, 0);
        run(0, 2'd0, 3'd5, 3'd0, 16'h0000, 0);

        // Randomized traffic on both instances.
        for (int t = 0; t < 60; t++) begin
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 2)));
        end

        // Final register contents against the architectural model.
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk("final_regs8", regs8[i], ref_mem[0][i]);
        for (int i = 0; i < 6; i++) chk("final_regs6", regs6[i], ref_mem[1][i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Strobe invariant: at most one strobe bit across read and write, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot8", 32'($countones({if8.reg_read_en, if8.reg_write_en}) <= 1), 1);
            chk("onehot6", 32'($countones({if6.reg_read_en, if6.reg_write_en}) <= 1), 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
